// File: rtl/dff_pkg.sv
// dff_pkg: shared constants and clog2 helper for the elastic register pipeline
package dff_pkg;
  localparam int DFF_PIPE_DEF_WIDTH = 8;
  localparam int DFF_PIPE_DEF_DEPTH = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline slot, a data register plus its valid bit
module dff_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             c,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic             clr,
  input  logic [WIDTH-1:0] src,
  output logic             valid_q,
  output logic             valid_d,
  output logic [WIDTH-1:0] data_q
);
  logic [WIDTH-1:0] data_d;
  always_comb begin
    valid_d = clr ? 1'b0 : load ? 1'b1 : adv ? 1'b0 : valid_q;
    data_d  = (load && !clr) ? src : data_q;
  end
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: elastic DEPTH-stage register pipeline with valid/ready and bubble collapsing
module dff_pipe
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
  parameter int DEPTH = DFF_PIPE_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          c,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [clog2(DEPTH+1)-1:0]     occupancy
);
  localparam int OW = clog2(DEPTH + 1);
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be at least 1");
  end
  logic [DEPTH-1:0] vld, vld_d, load, adv;
  logic [DEPTH:0]   free;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [OW-1:0]    occ_d, occ_q;
  // free[DEPTH] is the consumer; readiness ripples back stage by stage
  always_comb begin
    free = '0;
    adv  = '0;
    load = '0;
    free[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]  = vld[i] & free[i+1];
      free[i] = ~vld[i] | adv[i];
    end
    in_ready = free[0] & ~flush & ~rst;
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) load[i] = vld[i-1] & free[i];
  end
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d += OW'(vld_d[i]);
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src;
    if (i == 0) begin : g_head
      assign src = in_data;
    end else begin : g_body
      assign src = dat[i-1];
    end
    dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .c       (c),
      .rst     (rst),
      .load    (load[i]),
      .adv     (adv[i]),
      .clr     (flush),
      .src     (src),
      .valid_q (vld[i]),
      .valid_d (vld_d[i]),
      .data_q  (dat[i])
    );
  end
  always_ff @(posedge c or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: randomized and directed scoreboard bench for dff_pipe
module tb_dff_pipe;
  import dff_pkg::*;
  localparam int W = DFF_PIPE_DEF_WIDTH;
  localparam int D = DFF_PIPE_DEF_DEPTH;
  localparam int OW = clog2(D + 1);
  localparam logic [W-1:0] RV = 8'h5A;

  logic c = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [OW-1:0] occupancy;

  dff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .c         (c),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 c = ~c;

  typedef struct {
    logic [W-1:0] d;
    int           acc;
  } word_t;
  word_t q[$];
  int tests = 0, fails = 0, cyc = 0, last_pop = -100, vis;
  bit exp_v, exp_rdy;

  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a word accepted in cycle a is shown from cycle max(a+D, previous pop+1)
  always @(negedge c) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(RV));
      chk("rst_occupancy", 32'(occupancy), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0) begin
        vis = q[0].acc + D;
        if (last_pop + 1 > vis) vis = last_pop + 1;
        exp_v = cyc >= vis;
      end
      exp_rdy = !flush && (q.size() < D || out_ready);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (exp_v) chk("out_data", 32'(out_data), 32'(q[0].d));
      if (exp_v && out_valid && out_ready) begin
        void'(q.pop_front());
        last_pop = cyc;
      end
    end
  end

  always begin
    @(negedge c);
    #1;
    if (rst) q.delete();
    else begin
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back(word_t'{in_data, cyc});
    end
  end

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic push_n(input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = base + W'(k);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_valid = 1'b0;
    repeat (8) step();
    out_ready = 1'b0;
    push_n(5, 8'h40);
    chk("full_occupancy", 32'(occupancy), 32'(D));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 8'hA2; step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("bubble_occupancy", 32'(occupancy), 32'(2));
    chk("bubble_out_data", 32'(out_data), 32'(8'hA1));
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    push_n(4, 8'hC0);
    repeat (3) step();
    in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'(0));
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    chk("flush_occupancy", 32'(occupancy), 32'(0));
    repeat (6) step();
    out_ready = 1'b0;
    push_n(4, 8'h60);
    repeat (3) step();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      step();
      chk("stream_occupancy", 32'(occupancy), 32'(D));
    end
    in_valid = 1'b0;
    repeat (6) step();
    out_ready = 1'b0;
    push_n(3, 8'h90);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'(0));
    chk("async_out_data", 32'(out_data), 32'(RV));
    chk("async_occupancy", 32'(occupancy), 32'(0));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 31) == 0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
